// File: rtl/fanout_pack_param.sv
// rtl/fanout_pack_param.sv - broadcast/pack fan-out of a sample stream into LANES-wide words through a FIFO
module fanout_pack_param #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [LANES-1:0]      lane_mask,
    input  logic                  in_v,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_last,
    output logic                  in_rdy,
    input  logic                  halt,
    output logic                  out_v,
    output logic [DW*LANES-1:0]   out_data,
    output logic [LANES-1:0]      out_lanes,
    input  logic                  out_rdy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int CNTW = $clog2(LANES);
    localparam int WW   = DW * LANES;

    logic [WW-1:0]    mem       [DEPTH];
    logic [LANES-1:0] mem_lanes [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;

    logic [CNTW-1:0]  cnt;
    logic             word_mode;
    logic [WW-1:0]    stage_data;
    logic [LANES-1:0] stage_lanes;

    logic             full;
    logic             accept;
    logic             pop;
    logic             eff_mode;
    logic             close;
    logic             push;
    logic [WW-1:0]    push_data;
    logic [LANES-1:0] push_lanes;
    logic [WW-1:0]    pack_data;
    logic [LANES-1:0] pack_lanes;

    assign full   = (occ == CW'(DEPTH));
    assign in_rdy = rst && !halt && !full;
    assign accept = in_v && in_rdy;
    assign out_v  = (occ != '0);
    assign pop    = out_v && out_rdy && !halt;

    // Mode is sampled only when a word opens; mid-word changes wait for the close.
    assign eff_mode = (cnt == '0) ? mode : word_mode;

    assign out_data  = out_v ? mem[rd_ptr]       : '0;
    assign out_lanes = out_v ? mem_lanes[rd_ptr] : '0;

    always_comb begin
        pack_data  = stage_data;
        pack_lanes = stage_lanes;
        for (int i = 0; i < LANES; i++) begin
            if (CNTW'(i) == cnt) begin
                pack_data[i*DW +: DW] = in_data;
                pack_lanes[i]         = 1'b1;
            end
        end
    end

    always_comb begin
        push       = 1'b0;
        close      = 1'b0;
        push_data  = '0;
        push_lanes = '0;
        if (accept) begin
            if (!eff_mode) begin
                push       = |lane_mask;
                push_lanes = lane_mask;
                for (int i = 0; i < LANES; i++) begin
                    push_data[i*DW +: DW] = lane_mask[i] ? in_data : '0;
                end
            end else begin
                close      = (cnt == CNTW'(LANES - 1)) || in_last;
                push       = close;
                push_data  = pack_data;
                push_lanes = pack_lanes;
            end
        end
    end

    // Storage array needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]       <= push_data;
            mem_lanes[wr_ptr] <= push_lanes;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (!halt) begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            word_mode   <= 1'b0;
            stage_data  <= '0;
            stage_lanes <= '0;
        end else if (!halt && accept) begin
            if (cnt == '0) begin
                word_mode <= mode;
            end
            if (eff_mode) begin
                if (close) begin
                    cnt         <= '0;
                    stage_data  <= '0;
                    stage_lanes <= '0;
                end else begin
                    cnt         <= cnt + 1'b1;
                    stage_data  <= pack_data;
                    stage_lanes <= pack_lanes;
                end
            end
        end
    end

endmodule
